// File: rtl/fifo_rd_drain.sv
// Read-side drain controller: pops the FIFO in bursts (or continuously on flush)
// and feeds a valid/ready stream through a 2-entry skid buffer.
module fifo_rd_drain #(
  parameter int WIDTH = 8,
  parameter int PTR   = 4,
  parameter int BURST = 4
) (
  input  logic             rdclk,
  input  logic             reset_,
  input  logic             flush,
  input  logic             rdempty,
  input  logic [PTR:0]     rdusedw,
  input  logic [WIDTH-1:0] dataout,
  output logic             rden,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [15:0]      pop_cnt
);

  localparam int BCW = $clog2(BURST + 1);
  localparam logic [BCW-1:0] BURST_C = BCW'(BURST);
  localparam logic [PTR:0]   BURST_W = (PTR + 1)'(BURST);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t           state, state_nxt;
  logic [BCW-1:0]   burst_cnt, burst_nxt;
  logic             inflight;
  logic [1:0]       occ;
  logic [WIDTH-1:0] slot0, slot1;
  logic             pop;
  logic [2:0]       credit;
  logic             credit_ok;
  logic             limit_hit;

  // A pop is allowed only if its word will find a free slot when it returns.
  assign pop       = out_valid & out_ready;
  assign credit    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign credit_ok = (credit < 3'd2);
  assign rden      = reset_ & (state == DRAIN) & ~rdempty & credit_ok;
  assign limit_hit = (burst_cnt >= BURST_C) |
                     (rden & (burst_cnt == BURST_C - BCW'(1)));

  assign out_valid = (occ != 2'd0);
  assign out_data  = slot0;
  assign busy      = (state == DRAIN) | inflight | out_valid;

  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    if (state == IDLE) begin
      if ((rdusedw >= BURST_W) || (flush && !rdempty)) begin
        state_nxt = DRAIN;
        burst_nxt = '0;
      end
    end else begin
      if (rden && (burst_cnt < BURST_C))
        burst_nxt = burst_cnt + BCW'(1);
      if (!flush && limit_hit)
        state_nxt = IDLE;
      else if (rdempty && !rden)
        state_nxt = IDLE;
    end
  end

  // Clearing inflight on reset discards any word still returning from the FIFO.
  always_ff @(posedge rdclk) begin
    if (!reset_) begin
      state     <= IDLE;
      burst_cnt <= '0;
      inflight  <= 1'b0;
      occ       <= 2'd0;
      slot0     <= '0;
      slot1     <= '0;
      pop_cnt   <= 16'd0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      inflight  <= rden;
      if (rden)
        pop_cnt <= pop_cnt + 16'd1;
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0)
            slot0 <= dataout;
          else
            slot1 <= dataout;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            slot0 <= dataout;
          end else begin
            slot0 <= slot1;
            slot1 <= dataout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: a queue-based FIFO model feeds the DUT and the
// delivered stream is compared against the written word order.
module tb_fifo_rd_drain;
  localparam int WIDTH = 8;
  localparam int PTR   = 4;
  localparam int BURST = 4;

  logic             rdclk = 1'b0;
  logic             reset_ = 1'b0;
  logic             flush = 1'b0;
  logic             rdempty = 1'b1;
  logic [PTR:0]     rdusedw = '0;
  logic [WIDTH-1:0] dataout = '0;
  logic             rden;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             busy;
  logic [15:0]      pop_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int underflow = 0;
  int exp_pops = 0;
  bit clr_fifo = 1'b0;

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] wr_pend[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] got_data[$];
  int               got_cyc[$];
  int               rden_cyc[$];

  fifo_rd_drain #(.WIDTH(WIDTH), .PTR(PTR), .BURST(BURST)) dut (
    .rdclk(rdclk), .reset_(reset_), .flush(flush), .rdempty(rdempty),
    .rdusedw(rdusedw), .dataout(dataout), .rden(rden), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .pop_cnt(pop_cnt)
  );

  always #5 rdclk = ~rdclk;

  // FIFO with one-cycle read latency; written words become visible after the next edge.
  always @(posedge rdclk) begin
    cyc <= cyc + 1;
    if (clr_fifo) begin
      fifo_q.delete();
      wr_pend.delete();
    end else begin
      if (rden) begin
        if (fifo_q.size() == 0) underflow++;
        else dataout <= fifo_q.pop_front();
      end
      while (wr_pend.size() > 0) fifo_q.push_back(wr_pend.pop_front());
    end
    rdusedw <= (PTR + 1)'(fifo_q.size());
    rdempty <= (fifo_q.size() == 0);
  end

  always @(negedge rdclk) begin
    if (rden) rden_cyc.push_back(cyc);
    if (out_valid && out_ready) begin
      got_cyc.push_back(cyc);
      got_data.push_back(out_data);
    end
  end

  initial begin
    #1200000;
    $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge rdclk);
      #1;
    end
  endtask

  task automatic clear_logs();
    rden_cyc.delete();
    got_cyc.delete();
    got_data.delete();
    exp_q.delete();
  endtask

  task automatic write_word(input logic [WIDTH-1:0] d);
    wr_pend.push_back(d);
    exp_q.push_back(d);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge rdclk);
      if (!busy && !rden && fifo_q.size() == 0 && wr_pend.size() == 0) ok = 1'b1;
    end
    @(posedge rdclk);
    #1;
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    for (int i = 0; i < 4; i++) write_word(WIDTH'(8'hA0 + i));
    tick(3);
    @(negedge rdclk);
    n_cmp++; if (rden !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_rden: got %b want 0", rden); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_out_data: got %h want 00", out_data); end
    n_cmp++; if (pop_cnt !== 16'h0000) begin n_bad++; $display("[TB] FAIL reset_pop_cnt: got %h want 0000", pop_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    tick(1);
    clr_fifo = 1'b1;
    tick(1);
    clr_fifo = 1'b0;
    reset_ = 1'b1;
    exp_pops = 0;
    clear_logs();
    tick(2);
  endtask

  task automatic test_threshold_burst();
    bit ok;
    clear_logs();
    out_ready = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < 4; i++) write_word(WIDTH'(8'h11 + i));
    wait_idle(60, ok);
    exp_pops += 4;
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("[TB] FAIL burst_timeout: got busy want idle"); end
    n_cmp++; if (rden_cyc.size() != 4) begin n_bad++; $display("[TB] FAIL burst_pops: got %0d want 4", rden_cyc.size()); end
    if (rden_cyc.size() == 4) begin
      n_cmp++; if (rden_cyc[3] - rden_cyc[0] != 3) begin n_bad++; $display("[TB] FAIL burst_consecutive: got span %0d want 3", rden_cyc[3] - rden_cyc[0]); end
    end
    n_cmp++; if (got_data.size() != 4) begin n_bad++; $display("[TB] FAIL burst_words: got %0d want 4", got_data.size()); end
    if (got_data.size() == 4 && rden_cyc.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (got_data[i] !== exp_q[i]) begin n_bad++; $display("[TB] FAIL burst_data[%0d]: got %h want %h", i, got_data[i], exp_q[i]); end
        n_cmp++; if (got_cyc[i] != rden_cyc[0] + 2 + i) begin n_bad++; $display("[TB] FAIL burst_latency[%0d]: got cycle %0d want %0d", i, got_cyc[i], rden_cyc[0] + 2 + i); end
      end
    end
    n_cmp++; if (pop_cnt !== 16'(exp_pops)) begin n_bad++; $display("[TB] FAIL burst_pop_cnt: got %0d want %0d", pop_cnt, exp_pops); end
  endtask

  task automatic test_below_threshold();
    bit ok;
    clear_logs();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) write_word(WIDTH'(8'h21 + i));
    tick(10);
    n_cmp++; if (rden_cyc.size() != 0) begin n_bad++; $display("[TB] FAIL below_no_pop: got %0d pops want 0", rden_cyc.size()); end
    flush = 1'b1;
    wait_idle(60, ok);
    flush = 1'b0;
    exp_pops += 3;
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("[TB] FAIL flush_timeout: got busy want idle"); end
    n_cmp++; if (got_data.size() != 3) begin n_bad++; $display("[TB] FAIL flush_words: got %0d want 3", got_data.size()); end
    if (got_data.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (got_data[i] !== exp_q[i]) begin n_bad++; $display("[TB] FAIL flush_data[%0d]: got %h want %h", i, got_data[i], exp_q[i]); end
      end
    end
    n_cmp++; if (pop_cnt !== 16'(exp_pops)) begin n_bad++; $display("[TB] FAIL flush_pop_cnt: got %0d want %0d", pop_cnt, exp_pops); end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_logs();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) write_word(WIDTH'(8'h31 + i));
    tick(12);
    @(negedge rdclk);
    n_cmp++; if (rden_cyc.size() != 2) begin n_bad++; $display("[TB] FAIL bp_pops: got %0d want 2", rden_cyc.size()); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL bp_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== exp_q[0]) begin n_bad++; $display("[TB] FAIL bp_head: got %h want %h", out_data, exp_q[0]); end
    tick(5);
    @(negedge rdclk);
    n_cmp++; if (out_data !== exp_q[0]) begin n_bad++; $display("[TB] FAIL bp_stable: got %h want %h", out_data, exp_q[0]); end
    n_cmp++; if (rden !== 1'b0) begin n_bad++; $display("[TB] FAIL bp_rden_held: got %b want 0", rden); end
    tick(1);
    out_ready = 1'b1;
    @(negedge rdclk);
    n_cmp++; if (rden !== 1'b1) begin n_bad++; $display("[TB] FAIL bp_restart: got %b want 1", rden); end
    wait_idle(100, ok);
    exp_pops += 8;
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("[TB] FAIL bp_timeout: got busy want idle"); end
    n_cmp++; if (got_data.size() != 8) begin n_bad++; $display("[TB] FAIL bp_words: got %0d want 8", got_data.size()); end
    if (got_data.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++; if (got_data[i] !== exp_q[i]) begin n_bad++; $display("[TB] FAIL bp_data[%0d]: got %h want %h", i, got_data[i], exp_q[i]); end
      end
    end
    n_cmp++; if (pop_cnt !== 16'(exp_pops)) begin n_bad++; $display("[TB] FAIL bp_pop_cnt: got %0d want %0d", pop_cnt, exp_pops); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_logs();
    out_ready = 1'b1;
    flush = 1'b1;
    for (int i = 0; i < 16; i++) write_word(WIDTH'($urandom));
    wait_idle(100, ok);
    flush = 1'b0;
    exp_pops += 16;
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_timeout: got busy want idle"); end
    n_cmp++; if (rden_cyc.size() != 16) begin n_bad++; $display("[TB] FAIL b2b_pops: got %0d want 16", rden_cyc.size()); end
    n_cmp++; if (got_data.size() != 16) begin n_bad++; $display("[TB] FAIL b2b_words: got %0d want 16", got_data.size()); end
    if (rden_cyc.size() == 16 && got_data.size() == 16) begin
      n_cmp++; if (rden_cyc[15] - rden_cyc[0] != 15) begin n_bad++; $display("[TB] FAIL b2b_rden_span: got %0d want 15", rden_cyc[15] - rden_cyc[0]); end
      n_cmp++; if (got_cyc[15] - got_cyc[0] != 15) begin n_bad++; $display("[TB] FAIL b2b_out_span: got %0d want 15", got_cyc[15] - got_cyc[0]); end
      for (int i = 0; i < 16; i++) begin
        n_cmp++; if (got_data[i] !== exp_q[i]) begin n_bad++; $display("[TB] FAIL b2b_data[%0d]: got %h want %h", i, got_data[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_random();
    int  written;
    int  chunk;
    int  bad;
    bit  done;
    clear_logs();
    written = 0;
    done = 1'b0;
    for (int c = 0; c < 8000 && !done; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush = (written >= 1000) ? 1'b1 : ($urandom_range(0, 7) == 0);
      if (written < 1000 && $urandom_range(0, 1) == 1) begin
        chunk = $urandom_range(1, 4);
        for (int k = 0; k < chunk && written < 1000 && fifo_q.size() + wr_pend.size() < 16; k++) begin
          write_word(WIDTH'($urandom));
          written++;
        end
      end
      @(negedge rdclk);
      if (written == 1000 && got_data.size() == 1000 && !busy && fifo_q.size() == 0 && wr_pend.size() == 0)
        done = 1'b1;
      @(posedge rdclk);
      #1;
    end
    flush = 1'b0;
    out_ready = 1'b1;
    exp_pops += 1000;
    bad = 0;
    for (int i = 0; i < got_data.size() && i < exp_q.size(); i++)
      if (got_data[i] !== exp_q[i]) bad++;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("[TB] FAIL rand_timeout: got %0d words want 1000", got_data.size()); end
    n_cmp++; if (got_data.size() != 1000) begin n_bad++; $display("[TB] FAIL rand_words: got %0d want 1000", got_data.size()); end
    n_cmp++; if (bad != 0) begin n_bad++; $display("[TB] FAIL rand_order: got %0d wrong words want 0", bad); end
    n_cmp++; if (underflow != 0) begin n_bad++; $display("[TB] FAIL rand_underflow: got %0d want 0", underflow); end
    n_cmp++; if (pop_cnt !== 16'(exp_pops)) begin n_bad++; $display("[TB] FAIL rand_pop_cnt: got %0d want %0d", pop_cnt, 16'(exp_pops)); end
  endtask

  task automatic test_reset_mid_burst();
    bit seen;
    clear_logs();
    out_ready = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < 8; i++) write_word(WIDTH'(8'h61 + i));
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge rdclk);
      if (rden) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_mid_start: got no pop want pop"); end
    @(posedge rdclk);
    #1;
    reset_ = 1'b0;
    tick(1);
    @(negedge rdclk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_mid_valid: got %b want 0", out_valid); end
    n_cmp++; if (pop_cnt !== 16'h0000) begin n_bad++; $display("[TB] FAIL rst_mid_pop_cnt: got %h want 0000", pop_cnt); end
    n_cmp++; if (rden !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_mid_rden: got %b want 0", rden); end
    tick(1);
    clr_fifo = 1'b1;
    tick(1);
    clr_fifo = 1'b0;
    reset_ = 1'b1;
    exp_pops = 0;
    clear_logs();
    tick(15);
    @(negedge rdclk);
    n_cmp++; if (got_data.size() != 0) begin n_bad++; $display("[TB] FAIL rst_mid_stale: got %0d words want 0", got_data.size()); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_mid_busy: got %b want 0", busy); end
    tick(1);
  endtask

  task automatic test_pop_wrap();
    int  needed;
    int  written;
    int  bad;
    bit  done;
    bit  ok;
    clear_logs();
    needed = 65536 - exp_pops;
    written = 0;
    done = 1'b0;
    out_ready = 1'b1;
    flush = 1'b1;
    for (int c = 0; c < 70000 && !done; c++) begin
      for (int k = 0; k < 2 && written < needed && fifo_q.size() + wr_pend.size() < 10; k++) begin
        write_word(WIDTH'($urandom));
        written++;
      end
      @(negedge rdclk);
      if (written == needed && !busy && fifo_q.size() == 0 && wr_pend.size() == 0) done = 1'b1;
      @(posedge rdclk);
      #1;
    end
    flush = 1'b0;
    exp_pops += needed;
    bad = 0;
    for (int i = 0; i < got_data.size() && i < exp_q.size(); i++)
      if (got_data[i] !== exp_q[i]) bad++;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("[TB] FAIL wrap_timeout: got %0d words want %0d", got_data.size(), needed); end
    n_cmp++; if (got_data.size() != needed) begin n_bad++; $display("[TB] FAIL wrap_words: got %0d want %0d", got_data.size(), needed); end
    n_cmp++; if (bad != 0) begin n_bad++; $display("[TB] FAIL wrap_order: got %0d wrong words want 0", bad); end
    n_cmp++; if (pop_cnt !== 16'(exp_pops)) begin n_bad++; $display("[TB] FAIL wrap_pop_cnt: got %h want %h", pop_cnt, 16'(exp_pops)); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL wrap_valid: got %b want 0", out_valid); end
    clear_logs();
    write_word(WIDTH'(8'h5A));
    flush = 1'b1;
    wait_idle(40, ok);
    flush = 1'b0;
    exp_pops += 1;
    n_cmp++; if (pop_cnt !== 16'(exp_pops)) begin n_bad++; $display("[TB] FAIL wrap_after: got %h want %h", pop_cnt, 16'(exp_pops)); end
    n_cmp++; if (got_data.size() != 1) begin n_bad++; $display("[TB] FAIL wrap_after_words: got %0d want 1", got_data.size()); end
    if (got_data.size() == 1) begin
      n_cmp++; if (got_data[0] !== exp_q[0]) begin n_bad++; $display("[TB] FAIL wrap_after_data: got %h want %h", got_data[0], exp_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_threshold_burst();
    test_below_threshold();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_burst();
    test_pop_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
